// File: rtl/control_multiciclo_if.sv
// Control bundle between the multi-cycle controller and the MIPS datapath.
// master: controller side (takes opcode/flags/memory handshake, drives mux selects and enables).
// slave:  datapath side (mirror image). clk/reset stay plain ports on the modules.
interface control_multiciclo_if;
  logic [5:0] OP;
  logic       Zero;
  logic       Pos;
  logic       mem_ready;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOP;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  OP, Zero, Pos, mem_ready,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOP, PCSource, instr_done, illegal, state
  );

  modport slave (
    output OP, Zero, Pos, mem_ready,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOP, PCSource, instr_done, illegal, state
  );
endinterface

// File: rtl/control_multiciclo.sv
// Multi-cycle main controller: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over one ALU and one memory.
// Ports: clk, reset (async, active-high), bus (master modport: OP/Zero/Pos/mem_ready in, all datapath controls out).
// Memory wait: FETCH, MEMRD and MEMWR hold their strobes and address select until mem_ready.
module control_multiciclo (
  input  logic clk,
  input  logic reset,
  control_multiciclo_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  R_EX   = 4'd6,  R_WB   = 4'd7,
    IMM_EX = 4'd8,  IMM_WB = 4'd9,  BRANCH = 4'd10, JUMP   = 4'd11,
    ERROR  = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  state_t     st, nxt;
  logic [5:0] opQ;

  // op_q is captured in DECODE so later states ignore IR changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= FETCH;
      opQ <= 6'b000000;
    end else begin
      st <= nxt;
      if (st == DECODE) opQ <= bus.OP;
    end
  end

  // Next state. DECODE dispatches on the live opcode (it is being latched
  // this same cycle); every later decision looks only at opQ.
  always_comb begin
    nxt = st;
    case (st)
      FETCH:  nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.OP)
          OP_LW, OP_SW:                      nxt = MEMADR;
          OP_R:                              nxt = R_EX;
          OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI: nxt = IMM_EX;
          OP_BEQ, OP_BNE, OP_BGTZ:           nxt = BRANCH;
          OP_J:                              nxt = JUMP;
          default:                           nxt = ERROR;
        endcase
      end
      MEMADR: nxt = (opQ == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxt = bus.mem_ready ? MEMWB : MEMRD;
      MEMWB:  nxt = FETCH;
      MEMWR:  nxt = bus.mem_ready ? FETCH : MEMWR;
      R_EX:   nxt = R_WB;
      R_WB:   nxt = FETCH;
      IMM_EX: nxt = IMM_WB;
      IMM_WB: nxt = FETCH;
      BRANCH: nxt = FETCH;
      JUMP:   nxt = FETCH;
      ERROR:  nxt = ERROR;
      default: nxt = ERROR;  // unused codes 13-15
    endcase
  end

  // Outputs are decoded from the state register. FETCH, MEMWR and BRANCH
  // need same-cycle reaction to mem_ready / ALU flags, and reset must blank
  // everything asynchronously, so the decode stays combinational.
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemToReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUOP      = 4'b0000;
    bus.PCSource   = 2'b00;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    bus.state      = 4'd0;
    if (!reset) begin
      bus.state = st;
      case (st)
        FETCH: begin
          bus.MemRead = 1'b1;
          if (bus.mem_ready) begin
            bus.IRWrite = 1'b1;
            bus.ALUSrcB = 2'b01;
            bus.PCWrite = 1'b1;
          end
        end
        DECODE: bus.ALUSrcB = 2'b11;
        MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        MEMRD: begin
          bus.IorD    = 1'b1;
          bus.MemRead = 1'b1;
        end
        MEMWB: begin
          bus.MemToReg   = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        MEMWR: begin
          bus.IorD       = 1'b1;
          bus.MemWrite   = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        R_EX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOP   = 4'b0010;
        end
        R_WB: begin
          bus.RegDst     = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        IMM_EX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          case (opQ)
            OP_ORI:  bus.ALUOP = 4'b0001;
            OP_ANDI: bus.ALUOP = 4'b0011;
            OP_SLTI: bus.ALUOP = 4'b0110;
            default: bus.ALUOP = 4'b0000;
          endcase
        end
        IMM_WB: begin
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        BRANCH: begin
          bus.ALUSrcA    = 1'b1;
          bus.PCSource   = 2'b01;
          bus.instr_done = 1'b1;
          case (opQ)
            OP_BEQ: begin
              bus.ALUOP   = 4'b0111;
              bus.PCWrite = bus.Zero;
            end
            OP_BNE: begin
              bus.ALUOP   = 4'b1000;
              bus.PCWrite = ~bus.Zero;
            end
            default: begin
              bus.ALUOP   = 4'b1001;
              bus.PCWrite = bus.Pos;
            end
          endcase
        end
        JUMP: begin
          bus.PCSource   = 2'b10;
          bus.PCWrite    = 1'b1;
          bus.instr_done = 1'b1;
        end
        ERROR:   bus.illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: directed instructions from the test plan, then a random
// instruction stream with random memory waits, flags and post-DECODE opcode noise.
// Every cycle the full control vector is compared against the expected per-instruction cycle profile.
module tb_control_multiciclo;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_multiciclo_if bus ();
  control_multiciclo dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic       pcw, iord, mrd, mwr, irw, regdst, m2r, rw, srca;
    logic [1:0] srcb;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
    logic       done, ill;
    logic [3:0] st;
  } exp_t;

  localparam logic [5:0] R = 6'b000000, J = 6'b000010, BEQ = 6'b000100, BNE = 6'b000101,
                         BGTZ = 6'b000111, ADDI = 6'b001000, SLTI = 6'b001010,
                         ANDI = 6'b001100, ORI = 6'b001101, LW = 6'b100011, SW = 6'b101011;
  logic [5:0] legal [11] = '{R, J, BEQ, BNE, BGTZ, ADDI, SLTI, ANDI, ORI, LW, SW};

  function automatic exp_t actual();
    return exp_t'({bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
                   bus.MemToReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOP,
                   bus.PCSource, bus.instr_done, bus.illegal, bus.state});
  endfunction

  function automatic exp_t idle(input logic [3:0] s);
    exp_t e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic check(input string tag, input exp_t e);
    exp_t a;
    a = actual();
    checks++;
    assert (a === e) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, a, e);
  endtask

  // One clock cycle: drive inputs on the falling edge, compare 1 time unit later.
  task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                     input logic z, input logic p, input exp_t e);
    @(negedge clk);
    bus.OP = op; bus.mem_ready = rdy; bus.Zero = z; bus.Pos = p;
    #1;
    check(tag, e);
  endtask

  // Expected profile of one instruction built from the opcode semantics.
  // postOp < 0: random opcode noise after DECODE; abortAfter > 0: stop inside the memory wait.
  task automatic runInstr(input logic [5:0] op, input int fw, input int mw,
                          input logic z, input logic p, input int postOp,
                          input int errHold, input int abortAfter);
    exp_t e;
    logic [5:0] po;
    for (int i = 0; i < fw; i++) begin
      e = idle(0); e.mrd = 1;
      cyc("fetch_wait", r6(), 1'b0, rb(), rb(), e);
    end
    e = idle(0); e.mrd = 1; e.irw = 1; e.srcb = 2'b01; e.pcw = 1;
    cyc("fetch", r6(), 1'b1, rb(), rb(), e);
    e = idle(1); e.srcb = 2'b11;
    cyc("decode", op, rb(), rb(), rb(), e);
    po = (postOp < 0) ? r6() : 6'(postOp);
    case (op)
      R: begin
        e = idle(6); e.srca = 1; e.aluop = 4'b0010;
        cyc("r_ex", po, rb(), rb(), rb(), e);
        e = idle(7); e.regdst = 1; e.rw = 1; e.done = 1;
        cyc("r_wb", (postOp < 0) ? r6() : po, rb(), rb(), rb(), e);
      end
      ADDI, ORI, ANDI, SLTI: begin
        e = idle(8); e.srca = 1; e.srcb = 2'b10;
        e.aluop = (op == ORI) ? 4'b0001 : (op == ANDI) ? 4'b0011 : (op == SLTI) ? 4'b0110 : 4'b0000;
        cyc("imm_ex", po, rb(), rb(), rb(), e);
        e = idle(9); e.rw = 1; e.done = 1;
        cyc("imm_wb", (postOp < 0) ? r6() : po, rb(), rb(), rb(), e);
      end
      LW, SW: begin
        e = idle(2); e.srca = 1; e.srcb = 2'b10;
        cyc("memadr", po, rb(), rb(), rb(), e);
        e = idle((op == LW) ? 4'd3 : 4'd5); e.iord = 1;
        if (op == LW) e.mrd = 1; else e.mwr = 1;
        for (int i = 0; i < mw; i++) begin
          cyc("mem_wait", r6(), 1'b0, rb(), rb(), e);
          if (abortAfter > 0 && i + 1 == abortAfter) return;
        end
        if (op == SW) e.done = 1;
        cyc("mem_rdy", r6(), 1'b1, rb(), rb(), e);
        if (op == LW) begin
          e = idle(4); e.m2r = 1; e.rw = 1; e.done = 1;
          cyc("memwb", r6(), rb(), rb(), rb(), e);
        end
      end
      BEQ, BNE, BGTZ: begin
        e = idle(10); e.srca = 1; e.pcsrc = 2'b01; e.done = 1;
        e.aluop = (op == BEQ) ? 4'b0111 : (op == BNE) ? 4'b1000 : 4'b1001;
        e.pcw = (op == BEQ) ? z : (op == BNE) ? !z : p;
        cyc("branch", po, rb(), z, p, e);
      end
      J: begin
        e = idle(11); e.pcsrc = 2'b10; e.pcw = 1; e.done = 1;
        cyc("jump", po, rb(), rb(), rb(), e);
      end
      default: begin
        e = idle(12); e.ill = 1;
        for (int i = 0; i < errHold; i++) cyc("error_hold", r6(), rb(), rb(), rb(), e);
      end
    endcase
  endtask

  task automatic doReset();
    exp_t e;
    @(negedge clk);
    reset = 1'b1; bus.mem_ready = 1'b1; bus.OP = r6();
    #1;
    check("reset_zero", idle(0));
    cyc("reset_hold", r6(), 1'b1, 1'b1, 1'b1, idle(0));
    @(negedge clk);
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    e = idle(0); e.mrd = 1;
    check("post_reset_fetch", e);
  endtask

  initial begin
    logic [5:0] op;
    bus.OP = '0; bus.Zero = 0; bus.Pos = 0; bus.mem_ready = 0;
    reset = 1'b1;
    #2;
    check("reset_initial", idle(0));
    doReset();

    // Directed sequence from the test plan
    runInstr(R,    0, 0, 0, 0, -1, 0, 0);
    runInstr(LW,   0, 2, 0, 0, -1, 0, 0);
    runInstr(BEQ,  1, 0, 1, 0, -1, 0, 0);
    runInstr(BNE,  0, 0, 1, 0, -1, 0, 0);
    runInstr(BGTZ, 0, 0, 0, 1, -1, 0, 0);
    runInstr(J,    0, 0, 0, 0, -1, 0, 0);
    runInstr(ORI,  0, 0, 0, 0, int'(J), 0, 0);
    runInstr(SW,   2, 1, 0, 0, -1, 0, 0);

    // Random instruction stream
    for (int n = 0; n < 60; n++) begin
      op = legal[$urandom_range(0, 10)];
      runInstr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb(), rb(), -1, 0, 0);
    end

    // Illegal opcode: absorbing ERROR, then recover through reset
    runInstr(6'b111111, 0, 0, 0, 0, -1, 10, 0);
    doReset();
    do op = r6(); while (op inside {R, J, BEQ, BNE, BGTZ, ADDI, SLTI, ANDI, ORI, LW, SW});
    runInstr(op, 1, 0, 0, 0, -1, 3, 0);
    doReset();

    // Reset in the middle of a store wait: MemWrite must drop without a clock edge
    runInstr(SW, 0, 3, 0, 0, -1, 0, 2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_memwr", idle(0));
    @(negedge clk);
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    begin
      exp_t e;
      e = idle(0); e.mrd = 1;
      check("fetch_after_midreset", e);
    end
    runInstr(R, 0, 0, 0, 0, -1, 0, 0);
    runInstr(LW, 1, 1, 0, 0, -1, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
